// File: rtl/uart_word_tx_pkg.sv
// rtl/uart_word_tx_pkg.sv - shared states, frame constants and byte-order helpers for uart_word_tx
package uart_word_tx_pkg;

    localparam int DEF_CLKS_PER_BIT = 434;
    localparam int DATA_BITS        = 8;
    localparam int BYTES_PER_WORD   = 4;

    // 3-bit state codes shared by the word sequencer and the byte serializer
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_LOAD  = 3'd3,
        ST_START = 3'd4,
        ST_DATA  = 3'd5,
        ST_STOP  = 3'd6
    } state_t;

    // Byte that goes on the line next, taken from the end the byte order selects
    function automatic logic [7:0] first_byte(input logic [31:0] word, input logic msb_first);
        return msb_first ? word[31:24] : word[7:0];
    endfunction

    // Word with the byte just sent shifted out
    function automatic logic [31:0] drop_byte(input logic [31:0] word, input logic msb_first);
        return msb_first ? {word[23:0], 8'h00} : {8'h00, word[31:8]};
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - one 8N1 frame serializer with start/done handshake
module uart_tx_byte
    import uart_word_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic [7:0] i_byte,
    output logic       o_tx,
    output logic       o_done
);

    localparam int            BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

    state_t        r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          w_bit_end;

    assign w_bit_end = (r_baud == BAUD_LAST);
    // done marks the last cycle of the stop bit so the next start can follow with no gap
    assign o_done    = (r_state == ST_STOP) && w_bit_end;
    assign o_tx      = r_tx;

    // Frame FSM: baud counter reloads at every bit boundary, line driven from a register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state <= ST_START;
                        r_tx    <= 1'b0;
                        r_baud  <= '0;
                        r_shift <= i_byte;
                    end
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_tx    <= r_shift[0];
                        r_shift <= {1'b0, r_shift[7:1]};
                        r_state <= ST_DATA;
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (r_bit == BIT_LAST) begin
                            r_state <= ST_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_tx    <= r_shift[0];
                            r_shift <= {1'b0, r_shift[7:1]};
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                ST_STOP: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (i_start) begin
                            r_state <= ST_START;
                            r_tx    <= 1'b0;
                            r_shift <= i_byte;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_word_tx.sv
// rtl/uart_word_tx.sv - pops 32-bit FIFO words and sends each as four UART 8N1 frames
module uart_word_tx
    import uart_word_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT   = DEF_CLKS_PER_BIT,
    parameter int RD_LATENCY     = 3,
    parameter int BYTE_MSB_FIRST = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        fifo_empty,
    input  logic [31:0] fifo_rd_data,
    output logic        fifo_rd_en,
    output logic        tx,
    output logic        busy,
    output logic [15:0] words_sent
);

    localparam int            LW        = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [LW-1:0] LAT_LOAD  = LW'(RD_LATENCY - 1);
    localparam logic [1:0]    LAST_BYTE = 2'(BYTES_PER_WORD - 1);
    localparam logic          MSB_FIRST = (BYTE_MSB_FIRST != 0);

    state_t        r_state;
    logic          r_rd_en;
    logic          r_busy;
    logic [15:0]   r_words;
    logic [LW-1:0] r_lat;
    logic [31:0]   r_shift;
    logic [1:0]    r_byte_idx;
    logic          w_start;
    logic          w_done;
    logic          w_tx;
    logic [7:0]    w_byte;

    // First byte comes straight from the FIFO bus in LOAD; later bytes chain onto the previous stop bit
    assign w_start = (r_state == ST_LOAD) ||
                     ((r_state == ST_START) && w_done && (r_byte_idx != LAST_BYTE));
    assign w_byte  = (r_state == ST_LOAD) ? first_byte(fifo_rd_data, MSB_FIRST)
                                          : first_byte(r_shift, MSB_FIRST);

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_byte (
        .clk    (clk),
        .rst    (rst),
        .i_start(w_start),
        .i_byte (w_byte),
        .o_tx   (w_tx),
        .o_done (w_done)
    );

    assign fifo_rd_en = r_rd_en;
    assign tx         = w_tx;
    assign busy       = r_busy;
    assign words_sent = r_words;

    // Word sequencer: FIFO pop, read-latency wait, byte stepping; ST_START covers all four frames in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_rd_en    <= 1'b0;
            r_busy     <= 1'b0;
            r_words    <= '0;
            r_lat      <= '0;
            r_shift    <= '0;
            r_byte_idx <= '0;
        end else begin
            r_rd_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // empty flag lags the pop, so it is only trusted here
                    if (enable && !fifo_empty) begin
                        r_state <= ST_REQ;
                        r_rd_en <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                ST_REQ: begin
                    r_lat   <= LAT_LOAD;
                    r_state <= (RD_LATENCY == 1) ? ST_LOAD : ST_WAIT;
                end
                ST_WAIT: begin
                    r_lat <= r_lat - LW'(1);
                    if (r_lat == LW'(1)) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_shift    <= drop_byte(fifo_rd_data, MSB_FIRST);
                    r_byte_idx <= '0;
                    r_state    <= ST_START;
                end
                ST_START: begin
                    if (w_done) begin
                        if (r_byte_idx == LAST_BYTE) begin
                            r_words <= r_words + 16'd1;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_byte_idx <= r_byte_idx + 2'd1;
                            r_shift    <= drop_byte(r_shift, MSB_FIRST);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
